execute_stage_mc: RTL and testbench

//  Parametrised EX stage: forwarding muxes, single-cycle ALU ops and an iterative multi-cycle signed multiplier.

---
 rtl/exec_pkg.sv | 20 ++
 rtl/execute_stage_mc_if.sv | 20 ++
 rtl/exec_alu.sv | 39 +++
 rtl/execute_stage_mc.sv | 82 ++++++++
 tb/tb_execute_stage_mc.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, forwarding-select encodings and FSM state shared by the EX stage.
package exec_pkg;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_BNE   = 4'h9;
  localparam logic [3:0] OP_BLT   = 4'hA;
  localparam logic [3:0] OP_BGE   = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_MULH  = 4'hF;
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef enum logic {IDLE, MUL_RUN} state_t;
endpackage

// File: rtl/execute_stage_mc_if.sv
// execute_stage_mc_if: ID/EX-side operands/controls in, registered EX results and stall out.
// master = ID/EX + hazard side, slave = the EX stage.
interface execute_stage_mc_if #(parameter int DATA_W = 8, parameter int OP_W = 4);
  logic              flush, in_valid, ALUsrc, dir;
  logic [DATA_W-1:0] reg1, reg2, immediate, alu_result_mem, write_data_wb;
  logic [OP_W-1:0]   opcode;
  logic [1:0]        forwardA, forwardB;
  logic [DATA_W-1:0] alu_result;
  logic              zero, branch_taken, out_valid, stall;
  modport master (
    output flush, in_valid, ALUsrc, dir, reg1, reg2, immediate, alu_result_mem, write_data_wb,
           opcode, forwardA, forwardB,
    input  alu_result, zero, branch_taken, out_valid, stall
  );
  modport slave (
    input  flush, in_valid, ALUsrc, dir, reg1, reg2, immediate, alu_result_mem, write_data_wb,
           opcode, forwardA, forwardB,
    output alu_result, zero, branch_taken, out_valid, stall
  );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational single-cycle ALU; ports opcode/dir/a/b in, result/zero/branch_taken out.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]          opcode,
  input  logic                     dir,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result,
  output logic                     zero,
  output logic                     branch_taken
);
  localparam int SH_W = $clog2(DATA_W);
  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];
  // branches also produce a-b so zero reflects operand equality
  always_comb begin
    result = '0;
    branch_taken = 1'b0;
    case (opcode)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SHIFT: result = dir ? a >>> sh : a << sh;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, a < b};
      OP_BEQ:   begin result = a - b; branch_taken = a == b; end
      OP_BNE:   begin result = a - b; branch_taken = a != b; end
      OP_BLT:   begin result = a - b; branch_taken = a < b;  end
      OP_BGE:   begin result = a - b; branch_taken = a >= b; end
      default:  ;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: EX stage with forwarding, single-cycle ALU and iterative signed multiply.
// Ports: clk, reset (async, active-high), bus (execute_stage_mc_if.slave).
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input logic               clk,
  input logic               reset,
  execute_stage_mc_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        mag_b, mul_res;
  logic [2*DATA_W-1:0]      mcand, acc, acc_nxt, prod;
  logic                     sign, mulh, mul_op, z, br;
  logic signed [DATA_W-1:0] op_a, op_b, res;
  // |v| in DATA_W unsigned bits; the most negative value maps to 2^(DATA_W-1) without overflow
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction
  assign op_a = bus.forwardA == FWD_WB ? bus.write_data_wb :
                bus.forwardA == FWD_MEM ? bus.alu_result_mem : bus.reg1;
  assign op_b = bus.ALUsrc ? bus.immediate :
                bus.forwardB == FWD_WB ? bus.write_data_wb :
                bus.forwardB == FWD_MEM ? bus.alu_result_mem : bus.reg2;
  assign mul_op = bus.opcode == OP_MUL || bus.opcode == OP_MULH;
  exec_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .opcode(bus.opcode), .dir(bus.dir), .a(op_a), .b(op_b),
    .result(res), .zero(z), .branch_taken(br)
  );
  // the final step's add is folded in so the result lands at the cnt==1 edge
  assign acc_nxt = acc + (mag_b[0] ? mcand : '0);
  assign prod    = sign ? -acc_nxt : acc_nxt;
  assign mul_res = mulh ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
  // released in the last iteration so ID/EX advances exactly as the product is registered
  assign bus.stall = !bus.flush && (state == IDLE ? bus.in_valid && mul_op : cnt > CNT_W'(1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      state <= IDLE;
      cnt <= '0;
      bus.alu_result <= '0;
      bus.zero <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.out_valid <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mag_b <= '0;
      sign <= 1'b0;
      mulh <= 1'b0;
    end else if (state == IDLE) begin
      bus.out_valid <= bus.in_valid && !mul_op;
      bus.branch_taken <= bus.in_valid && !mul_op && br;
      if (bus.in_valid && !mul_op) begin
        bus.alu_result <= res;
        bus.zero <= z;
      end
      if (bus.in_valid && mul_op) begin
        state <= MUL_RUN;
        cnt <= CNT_W'(DATA_W);
        acc <= '0;
        mcand <= {{DATA_W{1'b0}}, mag(op_a)};
        mag_b <= mag(op_b);
        sign <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
        mulh <= bus.opcode == OP_MULH;
      end
    end else begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mag_b <= mag_b >> 1;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state <= IDLE;
        bus.out_valid <= 1'b1;
        bus.alu_result <= mul_res;
        bus.zero <= mul_res == '0;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: directed and random checks of execute_stage_mc against an integer reference model.
module tb_execute_stage_mc;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int exp_res = 0;
  bit exp_zero = 1'b0;
  int ops[13] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 14, 15};
  execute_stage_mc_if #(.DATA_W(W), .OP_W(4)) bus();
  execute_stage_mc #(.DATA_W(W), .OP_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic int fwd(int sel, int r, int wb, int mem);
    return sel == 1 ? wb : sel == 2 ? mem : r;
  endfunction
  // reference: signed integer arithmetic, result reduced to W bits
  function automatic void model(int op, int a, int b, bit dir, output int res, output bit br);
    br = 1'b0;
    res = 0;
    case (op)
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = dir ? (a >>> (b & 7)) : (a << (b & 7));
      6: res = int'(a < b);
      8: begin res = a - b; br = a == b; end
      9: begin res = a - b; br = a != b; end
      10: begin res = a - b; br = a < b; end
      11: begin res = a - b; br = a >= b; end
      14: res = a * b;
      15: res = (a * b) >>> W;
      default: res = 0;
    endcase
    res = res & 255;
  endfunction
  task automatic drive(int op, int r1, int r2, int imm, bit src, bit dir, int fa, int fb, int mem, int wb);
    bus.opcode = 4'(op);
    bus.reg1 = 8'(r1);
    bus.reg2 = 8'(r2);
    bus.immediate = 8'(imm);
    bus.ALUsrc = src;
    bus.dir = dir;
    bus.forwardA = 2'(fa);
    bus.forwardB = 2'(fb);
    bus.alu_result_mem = 8'(mem);
    bus.write_data_wb = 8'(wb);
    bus.in_valid = 1'b1;
  endtask
  task automatic run(string tag, int op, int r1, int r2, int imm, bit src, bit dir,
                     int fa, int fb, int mem, int wb);
    int a, b, res, stalls, edges;
    bit br, got;
    drive(op, r1, r2, imm, src, dir, fa, fb, mem, wb);
    a = fwd(fa, r1, wb, mem);
    b = src ? imm : fwd(fb, r2, wb, mem);
    model(op, a, b, dir, res, br);
    #1;
    if (op >= 14) begin
      stalls = 0;
      edges = 0;
      got = 1'b0;
      while (!got && edges < 3 * W) begin
        if (bus.stall) stalls++;
        @(posedge clk);
        #1;
        edges++;
        if (bus.out_valid) begin
          got = 1'b1;
          bus.in_valid = 1'b0;
        end else begin
          chk({tag, ":hold"}, bus.alu_result, exp_res);
          chk({tag, ":br_run"}, bus.branch_taken, 0);
        end
      end
      chk({tag, ":done"}, got, 1);
      chk({tag, ":stalls"}, stalls, W);
      chk({tag, ":edges"}, edges, W + 1);
      chk({tag, ":br"}, bus.branch_taken, 0);
    end else begin
      chk({tag, ":stall"}, bus.stall, 0);
      @(posedge clk);
      #1;
      chk({tag, ":valid"}, bus.out_valid, 1);
      chk({tag, ":br"}, bus.branch_taken, br);
    end
    chk({tag, ":res"}, bus.alu_result, res);
    chk({tag, ":zero"}, bus.zero, res == 0);
    exp_res = res;
    exp_zero = res == 0;
  endtask
  task automatic bubble(string tag);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ":valid"}, bus.out_valid, 0);
    chk({tag, ":br"}, bus.branch_taken, 0);
    chk({tag, ":res"}, bus.alu_result, exp_res);
    chk({tag, ":zero"}, bus.zero, exp_zero);
    chk({tag, ":stall"}, bus.stall, 0);
  endtask
  task automatic chk_cleared(string tag);
    chk({tag, ":res"}, bus.alu_result, 0);
    chk({tag, ":zero"}, bus.zero, 0);
    chk({tag, ":br"}, bus.branch_taken, 0);
    chk({tag, ":valid"}, bus.out_valid, 0);
    chk({tag, ":stall"}, bus.stall, 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    reset = 1'b0;
    // 1: async reset in the middle of a multiply
    run("pre_add", 0, 20, 22, 0, 0, 0, 0, 0, 0, 0);
    drive(14, 5, 6, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_stall", bus.stall, 1);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_cleared("async_rst");
    #2 reset = 1'b0;
    exp_res = 0;
    exp_zero = 1'b0;
    run("post_rst_add", 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    // 2: forwarded ADD
    run("fwd_add", 0, 99, 3, 0, 0, 0, 2, 0, 5, 77);
    // 3/4: multiplies
    run("mul", 14, -3, 7, 0, 0, 0, 0, 0, 0, 0);
    bubble("mul_once");
    run("mulh_min", 15, -128, -128, 0, 0, 0, 0, 0, 0, 0);
    run("mul_min", 14, -128, 0, -128, 1, 0, 0, 0, 0, 0);
    // 5: flush in the third MUL_RUN cycle
    drive(14, 11, 13, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk_cleared("flushed");
    exp_res = 0;
    exp_zero = 1'b0;
    bubble("post_flush");
    run("sub", 1, 9, 4, 0, 0, 0, 0, 0, 0, 0);
    // flush in the accept cycle: multiply never starts
    drive(15, 100, 100, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b1;
    #1;
    chk("acc_flush_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_res = 0;
    exp_zero = 1'b0;
    #1;
    chk("acc_flush_idle", bus.stall, 0);
    bubble("acc_flush_b1");
    bubble("acc_flush_b2");
    // 6: bubbles after an ADD and after a taken branch
    run("add", 0, 40, 2, 0, 0, 0, 0, 0, 0, 0);
    bubble("bub_add");
    run("beq", 8, 7, 0, 0, 0, 0, 0, 1, 0, 7);
    bubble("bub_beq");
    // random mix
    for (int i = 0; i < 40; i++) begin
      run("rnd", ops[$urandom_range(0, 12)], int'($urandom_range(0, 255)) - 128,
          int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
          int'($urandom_range(0, 255)) - 128);
      if ($urandom_range(0, 3) == 0) bubble("rnd_bub");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
